// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: buffers CPU writes to UART_DATA in a byte FIFO and
// drains them through the shared memory data port, arbitrating with the CPU.
module uart_tx_scheduler #(
    parameter int          FIFO_DEPTH   = 8,
    parameter int          STARVE_LIMIT = 16,
    parameter logic [31:0] UART_DATA    = 32'h1000_0000,
    parameter logic [31:0] UART_STATUS  = 32'h1000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wstrb,
    input  logic        c_we,
    output logic [31:0] c_rdata,
    output logic        c_stall,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_we,
    input  logic [31:0] m_rdata,
    output logic        tx_idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_POLL, S_SEND} state_t;

    state_t           state;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [ST_W-1:0]  starve_cnt;

    logic fifo_full;
    logic is_udata;
    logic is_ustat;
    logic local_acc;
    logic pass_acc;
    logic fsm_want;
    logic blocked;
    logic force_fsm;
    logic fsm_go;
    logic push;
    logic pop;
    logic [7:0] head;

    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign head      = fifo_mem[rd_ptr];
    assign is_udata  = (c_addr == UART_DATA);
    assign is_ustat  = (c_addr == UART_STATUS);
    assign local_acc = c_req && (is_udata || is_ustat);
    assign pass_acc  = c_req && !local_acc;
    assign fsm_want  = (state == S_POLL) || (state == S_SEND);
    assign blocked   = fsm_want && pass_acc;
    // A forced grant only ever preempts a pass-through access, never a local one.
    assign force_fsm = blocked && (starve_cnt == ST_W'(STARVE_LIMIT));
    assign fsm_go    = fsm_want && (!pass_acc || force_fsm);
    assign push      = c_req && c_we && is_udata && !fifo_full;
    assign pop       = (state == S_SEND) && fsm_go;
    assign tx_idle   = (count == '0) && (state == S_IDLE);
    assign c_stall   = force_fsm || (c_req && c_we && is_udata && fifo_full);

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_we    = 1'b0;
        c_rdata = '0;
        if (fsm_go) begin
            if (state == S_POLL) begin
                m_addr = UART_STATUS;
            end else begin
                m_addr  = UART_DATA;
                m_wdata = {24'b0, head};
                m_wstrb = 4'b0001;
                m_we    = 1'b1;
            end
        end else if (pass_acc) begin
            m_addr  = c_addr;
            m_wdata = c_wdata;
            m_wstrb = c_wstrb;
            m_we    = c_we;
        end
        if (c_req && is_ustat) begin
            c_rdata = {31'b0, ~fifo_full};
        end else if (pass_acc && !force_fsm) begin
            c_rdata = m_rdata;
        end
    end

    // Byte storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= c_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;

            if (fsm_go) begin
                starve_cnt <= '0;
            end else if (blocked) begin
                starve_cnt <= starve_cnt + ST_W'(1);
            end

            case (state)
                S_IDLE: if (count != '0) state <= S_POLL;
                S_POLL: if (fsm_go && m_rdata[0]) state <= S_SEND;
                S_SEND: if (fsm_go) state <= (count_next != '0) ? S_POLL : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small memory/UART model.
module tb_uart_tx_scheduler;

    localparam logic [31:0] UART_DATA   = 32'h1000_0000;
    localparam logic [31:0] UART_STATUS = 32'h1000_0004;
    localparam logic [31:0] RAM_ADDR    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_we;
    logic [31:0] c_rdata;
    logic        c_stall;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_we;
    logic [31:0] m_rdata;
    logic        tx_idle;
    logic        uart_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] tx_log [$];

    uart_tx_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .c_req   (c_req),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_wstrb (c_wstrb),
        .c_we    (c_we),
        .c_rdata (c_rdata),
        .c_stall (c_stall),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_we    (m_we),
        .m_rdata (m_rdata),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    assign m_rdata = (m_addr == UART_STATUS) ? {31'b0, uart_ready} : (m_addr ^ 32'hCAFE_0000);

    always @(posedge clk) begin
        if (!rst && m_we && m_addr == UART_DATA) tx_log.push_back(m_wdata[7:0]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0; c_wstrb = '0;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        c_req = 1'b1; c_we = 1'b1; c_addr = a; c_wdata = d; c_wstrb = 4'b0001;
    endtask

    task automatic cpu_rd(input logic [31:0] a);
        c_req = 1'b1; c_we = 1'b0; c_addr = a; c_wdata = '0; c_wstrb = '0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        @(negedge clk);
        while (!tx_idle && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk(tag, {31'b0, tx_idle}, 32'd1);
        tick();
    endtask

    initial begin
        int nst;
        int at;
        int g;
        logic st;

        rst = 1'b1;
        uart_ready = 1'b1;
        set_idle();

        // Reset state
        @(negedge clk);
        chk("rst_stall", {31'b0, c_stall}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_m_wstrb", {28'b0, m_wstrb}, 32'd0);
        chk("rst_c_rdata", c_rdata, 32'd0);
        chk("rst_tx_idle", {31'b0, tx_idle}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single byte
        tx_log.delete();
        cpu_wr(UART_DATA, 32'h0000_0041);
        @(negedge clk);
        chk("sb_wr_stall", {31'b0, c_stall}, 32'd0);
        chk("sb_wr_m_we", {31'b0, m_we}, 32'd0);
        tick();
        set_idle();
        @(negedge clk);
        chk("sb_idle_busy", {31'b0, tx_idle}, 32'd0);
        tick();
        @(negedge clk);
        chk("sb_poll_addr", m_addr, UART_STATUS);
        chk("sb_poll_we", {31'b0, m_we}, 32'd0);
        tick();
        @(negedge clk);
        chk("sb_send_we", {31'b0, m_we}, 32'd1);
        chk("sb_send_addr", m_addr, UART_DATA);
        chk("sb_send_wdata", m_wdata, 32'h0000_0041);
        chk("sb_send_wstrb", {28'b0, m_wstrb}, 32'd1);
        tick();
        @(negedge clk);
        chk("sb_done_idle", {31'b0, tx_idle}, 32'd1);
        chk("sb_done_we", {31'b0, m_we}, 32'd0);
        chk("sb_log_n", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() > 0) chk("sb_log_0", {24'b0, tx_log[0]}, 32'h41);
        tick();

        // Burst of 8
        tx_log.delete();
        nst = 0;
        for (int i = 0; i < 8; i++) begin
            cpu_wr(UART_DATA, 32'h30 + 32'(i));
            @(negedge clk);
            if (c_stall) nst++;
            tick();
        end
        set_idle();
        drain("burst_drain");
        chk("burst_stalls", 32'(nst), 32'd0);
        chk("burst_log_n", 32'(tx_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < tx_log.size(); i++)
            chk("burst_byte", {24'b0, tx_log[i]}, 32'h30 + 32'(i));

        // Full FIFO with UART busy
        tx_log.delete();
        uart_ready = 1'b0;
        nst = 0;
        for (int i = 0; i < 8; i++) begin
            cpu_wr(UART_DATA, 32'h60 + 32'(i));
            @(negedge clk);
            if (c_stall) nst++;
            tick();
        end
        chk("full_fill_stalls", 32'(nst), 32'd0);
        cpu_rd(UART_STATUS);
        @(negedge clk);
        chk("full_status", c_rdata, 32'd0);
        chk("full_poll_shared", m_addr, UART_STATUS);
        tick();
        cpu_rd(UART_DATA);
        @(negedge clk);
        chk("data_read", c_rdata, 32'd0);
        tick();
        cpu_wr(UART_DATA, 32'h68);
        @(negedge clk);
        chk("full_wr_stall", {31'b0, c_stall}, 32'd1);
        chk("full_wr_no_mem", {31'b0, m_we}, 32'd0);
        tick();
        @(negedge clk);
        chk("full_wr_hold", {31'b0, c_stall}, 32'd1);
        tick();
        cpu_rd(UART_STATUS);
        uart_ready = 1'b1;
        @(negedge clk);
        chk("st_before_poll", c_rdata, 32'd0);
        tick();
        @(negedge clk);
        chk("st_send_we", {31'b0, m_we}, 32'd1);
        chk("st_send_wdata", m_wdata, 32'h60);
        chk("st_during_send", c_rdata, 32'd0);
        tick();
        @(negedge clk);
        chk("st_after_pop", c_rdata, 32'd1);
        tick();
        for (int i = 8; i < 10; i++) begin
            cpu_wr(UART_DATA, 32'h60 + 32'(i));
            g = 0;
            do begin
                @(negedge clk);
                st = c_stall;
                tick();
                g++;
            end while (st && g < 50);
            chk("full_wr_accept", {31'b0, st}, 32'd0);
        end
        set_idle();
        drain("full_drain");
        chk("full_log_n", 32'(tx_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < tx_log.size(); i++)
            chk("full_byte", {24'b0, tx_log[i]}, 32'h60 + 32'(i));

        // Starvation guard
        tx_log.delete();
        cpu_wr(UART_DATA, 32'h55);
        @(negedge clk);
        tick();
        cpu_rd(RAM_ADDR);
        nst = 0;
        at = -1;
        for (int r = 0; r <= 20; r++) begin
            @(negedge clk);
            if (r == 0) begin
                chk("pass_addr", m_addr, RAM_ADDR);
                chk("pass_rdata", c_rdata, 32'hCAFE_0100);
            end
            if (c_stall) begin
                nst++;
                at = r;
                chk("force_port", m_addr, UART_STATUS);
            end
            tick();
        end
        chk("starve_n", 32'(nst), 32'd1);
        chk("starve_at", 32'(at), 32'd17);
        set_idle();
        @(negedge clk);
        chk("starve_send_we", {31'b0, m_we}, 32'd1);
        chk("starve_send_wd", m_wdata, 32'h55);
        tick();
        drain("starve_drain");
        chk("starve_log_n", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() > 0) chk("starve_byte", {24'b0, tx_log[0]}, 32'h55);

        // Reset during SEND
        tx_log.delete();
        cpu_wr(UART_DATA, 32'h77);
        @(negedge clk);
        tick();
        cpu_wr(UART_DATA, 32'h78);
        @(negedge clk);
        tick();
        set_idle();
        g = 0;
        @(negedge clk);
        while (!m_we && g < 20) begin
            tick();
            @(negedge clk);
            g++;
        end
        chk("rs_send_seen", {31'b0, m_we}, 32'd1);
        chk("rs_send_wd", m_wdata, 32'h77);
        rst = 1'b1;
        #1;
        chk("rs_we_drop", {31'b0, m_we}, 32'd0);
        chk("rs_idle", {31'b0, tx_idle}, 32'd1);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("rs_no_stale", 32'(tx_log.size()), 32'd0);
        chk("rs_idle_after", {31'b0, tx_idle}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sits between the CPU data port and the unified memory data port.
- Decouples CPU UART output from the UART ready/busy pacing: CPU writes to UART_DATA go into a byte FIFO.
- A drain FSM borrows the memory data port on idle cycles, polls UART_STATUS, and issues the TX write.
- Arbitrates the single memory data port between CPU and drain FSM, with a starvation guard.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 16, consecutive cycles the FSM waits for the port before forcing a CPU stall; >= 1.
- UART_DATA, 32'h1000_0000, TX data register address.
- UART_STATUS, 32'h1000_0004, status register address.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- c_req  input  1  CPU data access valid this cycle (read or write).
- c_addr  input  32  CPU data address.
- c_wdata  input  32  CPU write data.
- c_wstrb  input  4  CPU byte enables.
- c_we  input  1  CPU write.
- c_rdata  output  32  CPU read data.
- c_stall  output  1  CPU must hold its access; the access is not performed this cycle.
- m_addr  output  32  to memory d_addr.
- m_wdata  output  32  to memory d_wdata.
- m_wstrb  output  4  to memory d_wstrb.
- m_we  output  1  to memory d_we.
- m_rdata  input  32  from memory d_rdata (combinational).
- tx_idle  output  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (async): FIFO empty (rd/wr pointers 0, count 0), FSM=IDLE, starve counter 0. Outputs: c_stall=0, m_we=0, m_addr=0, m_wdata=0, m_wstrb=0, c_rdata=0, tx_idle=1.
- CPU ownership (grant=CPU): c_req=1 and not a forced stall.
- UART_DATA write (c_we=1, c_addr==UART_DATA):
  - Never reaches memory.
  - If the FIFO is not full, push c_wdata[7:0] at the clock edge.
  - If the FIFO is full, c_stall=1 with no push. No same-cycle bypass when full.
- UART_STATUS read: c_rdata = {31'b0, ~fifo_full}, served locally.
- UART_DATA read: c_rdata = 0, served locally.
- Other CPU accesses pass through: m_* = c_*, c_rdata = m_rdata.
- Local UART_DATA/UART_STATUS accesses do not occupy the memory port; the FSM may use it the same cycle.
- Drain FSM states:
  - IDLE: if the FIFO is non-empty, go to POLL.
  - POLL: when the port is free, drive m_addr=UART_STATUS, m_we=0, and sample m_rdata[0] at the edge.
    - Bit 1: go to SEND.
    - Bit 0: stay in POLL.
  - SEND: when the port is free, drive m_addr=UART_DATA, m_wdata={24'b0, head}, m_wstrb=4'b0001, m_we=1. Pop the FIFO at the edge, then go to POLL if the FIFO is still non-empty after the pop, else IDLE.
- Port busy (CPU pass-through access) in POLL/SEND: FSM holds state, no sample, no pop.
- Starvation guard:
  - The counter increments each cycle the FSM is in POLL/SEND and blocked by a CPU pass-through.
  - It resets to 0 on any cycle the FSM uses the port.
  - At count==STARVE_LIMIT, the next blocked cycle forces c_stall=1, gives the port to the FSM, and clears the counter.
- Simultaneous push and pop (SEND pop with a CPU UART_DATA push, FIFO not full): both occur, count unchanged, pointers wrap modulo FIFO_DEPTH.
- Count width: clog2(FIFO_DEPTH)+1.
- c_stall and all m_* outputs are combinational from state and CPU inputs. With c_req=0 and the FSM not driving the port, m_we=0 and m_addr=0.
- Reset mid-SEND: m_we drops immediately and queued bytes are discarded.
- Byte order: strict FIFO, with exactly one memory UART write per FIFO entry.

Test Plan:
- Single byte: CPU writes 0x41 to UART_DATA, then c_req=0. Expect POLL at cycle +1 and SEND at +2 with m_wdata=0x41, m_we=1, then tx_idle=1; memory prints "A".
- Burst: 8 back-to-back UART_DATA writes with CPU otherwise idle. Expect m_we pulses on UART_DATA in order (busy poll between sends), FIFO never full, no c_stall.
- Full FIFO: CPU issues 10 UART_DATA writes back to back with continuous c_req. Expect c_stall=1 on the 9th write while the FIFO is full. Forced stalls are acceptable while the FIFO is not full. All 10 bytes are emitted in order.
- Status: with the FIFO full, a CPU read of UART_STATUS returns 0x0. After one pop it returns 0x1.
- Starvation: FIFO holds 1 byte, CPU issues continuous RAM reads. Exactly one forced c_stall occurs after 16 blocked cycles, and the FSM advances.
- Reset: assert rst during SEND. Expect m_we=0 immediately, tx_idle=1 after release, and no stale byte emitted.
